// File: rtl/execute_muldiv_unit_pkg.sv
// Shared types and constants for the EX-stage iterative multiply/divide unit.
package execute_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_e;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/execute_muldiv_unit_iter.sv
// Shared 2*XLEN accumulator: one radix-2 shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle, operating on magnitudes.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_next
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m;
    logic [XLEN:0]     sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;

    // Multiply: acc = {partial hi, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, m};
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, m};
        if (is_div) begin
            if (diff[XLEN])
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            if (acc[0])
                acc_next = {sum, acc[XLEN-1:1]};
            else
                acc_next = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            m   <= is_div ? b : a;
            acc <= {{XLEN{1'b0}}, (is_div ? a : b)};
        end else if (step) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage; stalls the
// pipeline while iterating and pulses DONE with a registered RESULT/RD_out.
module execute_muldiv_unit
    import execute_muldiv_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int TAG_W     = 5,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             FLUSH,
    input  logic             VALID_in,
    input  logic [2:0]       OP_in,
    input  logic [XLEN-1:0]  OP1_in,
    input  logic [XLEN-1:0]  OP2_in,
    input  logic [TAG_W-1:0] RD_in,
    output logic             STALL,
    output logic             BUSY,
    output logic             DONE,
    output logic [XLEN-1:0]  RESULT,
    output logic [TAG_W-1:0] RD_out
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state;
    muldiv_op_e        op_in;
    muldiv_op_e        op_q;
    logic [CNT_W-1:0]  cnt;
    logic [TAG_W-1:0]  rd_q;
    logic              neg_q, rem_neg_q, dz_q;
    logic              done_q;

    logic              s1, s2, neg1, neg2, in_div, div_zero, sgn_ovf, early;
    logic [XLEN-1:0]   mag1, mag2, early_res, final_res, quo, rem;
    logic [2*XLEN-1:0] acc_next, prod;
    logic              accept, core_load, core_step, core_div;

    assign op_in  = muldiv_op_e'(OP_in);
    assign in_div = OP_in[2];

    always_comb begin
        s1        = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV)  || (op_in == OP_REM);
        s2        = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        neg1      = s1 & OP1_in[XLEN-1];
        neg2      = s2 & OP2_in[XLEN-1];
        mag1      = neg1 ? -OP1_in : OP1_in;
        mag2      = neg2 ? -OP2_in : OP2_in;
        div_zero  = in_div && (OP2_in == '0);
        sgn_ovf   = in_div && s2 && (OP1_in == MIN_INT) && (OP2_in == '1);
        early     = EARLY_OUT && (div_zero || sgn_ovf);
        // OP_in[1] selects the remainder among the divide ops
        if (div_zero)
            early_res = OP_in[1] ? OP1_in : '1;
        else
            early_res = OP_in[1] ? '0 : MIN_INT;
    end

    assign accept    = (state == IDLE) && VALID_in && !FLUSH;
    assign core_load = EN && !RST && accept;
    assign core_step = EN && !RST && (state == CALC);
    assign core_div  = (state == IDLE) ? in_div : op_q[2];

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (CLK),
        .load     (core_load),
        .step     (core_step),
        .is_div   (core_div),
        .a        (mag1),
        .b        (mag2),
        .acc_next (acc_next)
    );

    // Sign fix-up applied to the value the last step produces, so RESULT is
    // ready on the same edge that enters FIN.
    always_comb begin
        prod = neg_q ? -acc_next : acc_next;
        quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = rem_neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        if (dz_q) quo = '1;
        case (op_q)
            OP_MUL:                      final_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = quo;
            default:                     final_res = rem;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= OP_MUL;
            rd_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
            RESULT    <= '0;
            RD_out    <= '0;
        end else if (EN) begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        op_q      <= op_in;
                        rd_q      <= RD_in;
                        neg_q     <= neg1 ^ neg2;
                        rem_neg_q <= neg1;
                        dz_q      <= div_zero;
                        cnt       <= CNT_W'(XLEN-1);
                        if (early) begin
                            state  <= FIN;
                            done_q <= 1'b1;
                            RESULT <= early_res;
                            RD_out <= RD_in;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (FLUSH) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state  <= FIN;
                        done_q <= 1'b1;
                        RESULT <= final_res;
                        RD_out <= rd_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign STALL = ((state == IDLE) && VALID_in && !FLUSH) || (state == CALC);
    assign BUSY  = (state != IDLE);
    assign DONE  = done_q;

endmodule
